// File: rtl/nexys4ddr_reset_gen.sv
// Board reset sequencer: debounces CPU_RESETN, pulses the MMCM reset, waits for a stable lock.
// Define NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN to re-reset the MMCM when lock never arrives.
//
// state      | meaning
// MMCM_RST   | MMCM held in reset for MMCM_RESET_CYCLES
// WAIT_LOCK  | MMCM released, waiting for synced lock
// STABLE     | lock seen, must hold for LOCK_STABLE_CYCLES
// RUN        | sys_areset released
module nexys4ddr_reset_gen #(
    parameter int DEBOUNCE_BITS      = 16,
    parameter int MMCM_RESET_CYCLES  = 64,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT_BITS  = 20
) (
    input  logic       clock,
    input  logic       areset,
    input  logic       ck_rst_n,
    input  logic       mmcm_locked,
    output logic       mmcm_reset,
    output logic       sys_areset,
    output logic [3:0] lock_retries,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_MMCM_RST  = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_STABLE    = 2'b10,
        ST_RUN       = 2'b11
    } state_e;

    localparam int MRC_W  = $clog2(MMCM_RESET_CYCLES);
    localparam int LSC_W  = $clog2(LOCK_STABLE_CYCLES);
    localparam int BASE_W = (MRC_W > LSC_W) ? MRC_W : LSC_W;
`ifdef NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN
    localparam int CNT_W  = (BASE_W > LOCK_TIMEOUT_BITS) ? BASE_W : LOCK_TIMEOUT_BITS;
`else
    localparam int CNT_W  = BASE_W;
`endif

    logic btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
    logic [DEBOUNCE_BITS-1:0] dbc_q, dbc_d;
    logic btn_q, btn_d;
    logic btn_pressed;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic mmcm_reset_q, mmcm_reset_d;
    logic sys_areset_q, sys_areset_d;

    always_comb begin
        btn_meta_d  = ck_rst_n;
        btn_sync_d  = btn_meta_q;
        lock_meta_d = mmcm_locked;
        lock_sync_d = lock_meta_q;
    end

    // Button is active-low at the pin; btn_q is 1 while pressed.
    assign btn_pressed = ~btn_sync_q;

    always_comb begin
        dbc_d = '0;
        btn_d = btn_q;
        if (btn_pressed != btn_q) begin
            if (&dbc_q) begin
                btn_d = ~btn_q;
            end else begin
                dbc_d = dbc_q + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            btn_meta_q  <= 1'b1;
            btn_sync_q  <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            dbc_q       <= '0;
            btn_q       <= 1'b0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
            dbc_q       <= dbc_d;
            btn_q       <= btn_d;
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_q      <= ST_MMCM_RST;
            cnt_q        <= '0;
            mmcm_reset_q <= 1'b1;
            sys_areset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mmcm_reset_q <= mmcm_reset_d;
            sys_areset_q <= sys_areset_d;
        end
    end

`ifdef NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN
    logic timeout;
    logic [3:0] retries_q, retries_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN
        timeout = 1'b0;
`endif
        if (btn_q) begin
            state_d = ST_MMCM_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_MMCM_RST: begin
                    if (cnt_q == CNT_W'(MMCM_RESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle still wins.
                    if (lock_sync_q) begin
                        state_d = ST_STABLE;
                    end
`ifdef NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN
                    else if (cnt_q == CNT_W'({LOCK_TIMEOUT_BITS{1'b1}})) begin
                        state_d = ST_MMCM_RST;
                        timeout = 1'b1;
                    end
`else
                    else begin
                        cnt_d = '0;
                    end
`endif
                end
                ST_STABLE: begin
                    if (!lock_sync_q) state_d = ST_WAIT_LOCK;
                    else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = ST_RUN;
                end
                default: begin
                    cnt_d = '0;
                    if (!lock_sync_q) state_d = ST_MMCM_RST;
                end
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        mmcm_reset_d = (state_d == ST_MMCM_RST);
        sys_areset_d = (state_d != ST_RUN);
    end

`ifdef NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN
    always_comb begin
        retries_d = retries_q;
        if (timeout && (retries_q != 4'hF)) retries_d = retries_q + 4'd1;
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) retries_q <= 4'd0;
        else        retries_q <= retries_d;
    end

    assign lock_retries = retries_q;
`else
    assign lock_retries = 4'd0;
`endif

    assign mmcm_reset = mmcm_reset_q;
    assign sys_areset = sys_areset_q;
    assign state      = state_q;

endmodule

// File: doc/nexys4ddr_reset_gen.md
# nexys4ddr_reset_gen

Board-level reset generator for the Nexys4 DDR shell. Runs on the free-running 100 MHz board oscillator, sequences the MMCM reset and lock, and debounces the CPU_RESETN push-button. Its `sys_areset` output is the `areset` input of `nexys4ddr_reset`, which holds and distributes reset into the generated clock domains.

## Interface
Parameters:
- `DEBOUNCE_BITS`, 16: the button must be stable for 2^DEBOUNCE_BITS consecutive cycles before its debounced state changes.
- `MMCM_RESET_CYCLES`, 64: width of the `mmcm_reset` pulse, in cycles (≥2).
- `LOCK_STABLE_CYCLES`, 256: number of consecutive cycles the synchronized lock must stay high before reset is released (≥2).
- `LOCK_TIMEOUT_BITS`, 20: the lock wait times out after 2^LOCK_TIMEOUT_BITS cycles.

Ports:
- `clock` in 1: board oscillator.
- `areset` in 1: asynchronous, active-high (power-on / JTAG).
- `ck_rst_n` in 1: raw push-button, active-low, asynchronous.
- `mmcm_locked` in 1: MMCM lock, asynchronous.
- `mmcm_reset` out 1: MMCM RST.
- `sys_areset` out 1: active-high; drives `nexys4ddr_reset.areset`.
- `lock_retries` out 4: saturating count of lock timeouts.
- `state` out 2: current FSM state (debug).

## Operation
- `ck_rst_n` and `mmcm_locked` each pass through a 2-flop synchronizer.
  - Reset values: button sync = 1 (released); lock sync = 0.
- Button debounce:
  - Counter runs while the synced button differs from the debounced state, and clears when they match.
  - On the 2^DEBOUNCE_BITS-th consecutive differing cycle, the debounced `btn` flips.
  - `btn` reset value is 0 (not pressed).
- FSM, encoded as in `state`:
  - **MMCM_RST (00)**: `mmcm_reset`=1, `sys_areset`=1. Counter increments; at MMCM_RESET_CYCLES-1 → WAIT_LOCK. While `btn`=1, the counter is held at 0.
  - **WAIT_LOCK (01)**: `mmcm_reset`=0, `sys_areset`=1. Synced lock = 1 → STABLE.
  - **STABLE (10)**: `sys_areset`=1. Counter increments while lock = 1; at LOCK_STABLE_CYCLES-1 → RUN. Lock = 0 → WAIT_LOCK.
  - **RUN (11)**: `sys_areset`=0. Lock = 0 → MMCM_RST. Loss of lock always re-resets the MMCM.
- `btn`=1 in any state → MMCM_RST.
- Priority: `btn` > lock loss > timeout > normal advance.
- The shared counter clears on every state change.
- All outputs are registered from next state, so an output changes on the same edge as the state entry.
- `areset` asserted at any time, including mid-sequence:
  - Immediately, with no clock edge needed: state=MMCM_RST, `mmcm_reset`=1, `sys_areset`=1, all counters 0.
  - `lock_retries`=0 and `btn`=0.
  - Reset values above are the values of every output.

## Timing
- Cycle numbering: `areset` deasserts before edge 1.
  - `mmcm_reset` is high through edge MMCM_RESET_CYCLES-1 and falls at edge MMCM_RESET_CYCLES.
  - This assumes the button is not pressed.
- Lock release: `mmcm_locked` rises, meeting setup, before edge k.
  - Synced lock is high after edge k+1.
  - STABLE is entered at edge k+2.
  - `sys_areset` falls at edge k+2+LOCK_STABLE_CYCLES.
- Lock drop in STABLE: → WAIT_LOCK 2 cycles after the pin falls, and the count restarts.
- Button assertion latency to MMCM_RST: 2 sync cycles + 2^DEBOUNCE_BITS cycles + 1.
- Button release follows the same debounce, then the normal MMCM_RST sequence.
- A lock rise on the same edge as a timeout: lock wins, → STABLE.

## Configuration
- `NEXYS4DDR_RESET_GEN_LOCK_TIMEOUT_EN` defined:
  - WAIT_LOCK counter reaching 2^LOCK_TIMEOUT_BITS-1 with no lock → MMCM_RST.
  - `lock_retries` increments, saturating at 15.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - `lock_retries` is tied to 0.
  - No timeout counter logic is built.

## Test plan
Parameters for all scenarios: DEBOUNCE_BITS=4, MMCM_RESET_CYCLES=8, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_BITS=6.

- Power-on: `areset` high for 5 cycles, released, then `mmcm_locked` raised at edge 20.
  - `mmcm_reset` falls at edge 8.
  - STABLE at edge 22.
  - `sys_areset` falls at edge 38.
- Lock glitch: `mmcm_locked` low for 1 cycle at STABLE count 10.
  - → WAIT_LOCK, then STABLE again.
  - `sys_areset` falls 16 cycles after the new STABLE entry.
- Lock loss in RUN: drop `mmcm_locked`.
  - 3 cycles later: `sys_areset`=1, `mmcm_reset`=1, state=00.
- Button bounce:
  - 10-cycle low pulses: no effect.
  - Low held 40 cycles: MMCM_RST 19 cycles after the press.
  - Release: full sequence reruns.
- Timeout, with the macro defined, lock never asserted:
  - MMCM_RST re-entered every 64+8 cycles.
  - `lock_retries` counts 1, 2, …, 15 and holds at 15.
  - Without the macro: stays in 01 and `lock_retries`=0.
- `areset` pulsed mid-RUN, asynchronously and between edges:
  - `sys_areset` and `mmcm_reset` go high before the next edge.
  - All counters are 0 after release.
